// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, opcodes,
// datapath select codes and the bundled control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // Last state of every instruction flavour; leaving it retires the instruction.
    function automatic logic is_retire_state(input state_e s);
        case (s)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: is_retire_state = 1'b1;
            default:                                               is_retire_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decoder: maps the current controller state to the datapath control word.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e i_state,
    output ctrl_t  o_ctrl
);

    // State to control-word lookup; unused encodings leave everything deasserted.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: o_ctrl.iord = 1'b1;
            S_MEMWB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_SUB;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                o_ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: o_ctrl.reg_write = 1'b1;
            S_JUMP: begin
                o_ctrl.pc_src   = PCSRC_JUMP;
                o_ctrl.pc_write = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with retired-instruction counter and sticky illegal flag.
// Define MIPS_CTRL_MEM_READY_EN to make FETCH/MEMRD/MEMWR wait on the mem_ready handshake.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MIPS_CTRL_MEM_READY_EN
    input  logic             mem_ready,
`endif
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             pc_en,
    output logic             pc_write,
    output logic             branch,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_e           r_state;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;
    state_e           w_next_raw;
    state_e           w_next;
    logic             w_illegal_set;
    logic             w_hold;
    logic             w_fetch_ok;
    logic             w_retire;
    ctrl_t            w_ctrl;

    mips_ctrl_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

`ifdef MIPS_CTRL_MEM_READY_EN
    assign w_hold     = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                        && !mem_ready;
    assign w_fetch_ok = (r_state != S_FETCH) || mem_ready;
`else
    assign w_hold     = 1'b0;
    assign w_fetch_ok = 1'b1;
`endif

    // Next-state sequencing, ignoring memory wait states.
    always_comb begin
        w_next_raw    = S_FETCH;
        w_illegal_set = 1'b0;
        case (r_state)
            S_FETCH:  w_next_raw = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_raw = S_MEMADR;
                    OP_RTYPE:     w_next_raw = S_EXEC;
                    OP_BEQ:       w_next_raw = S_BRANCH;
                    OP_ADDI:      w_next_raw = S_ADDIEX;
                    OP_J:         w_next_raw = S_JUMP;
                    default: begin
                        w_next_raw    = S_FETCH;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    w_next_raw = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    w_next_raw = S_MEMWR;
                end else begin
                    w_next_raw = S_FETCH;
                end
            end
            S_MEMRD:  w_next_raw = S_MEMWB;
            S_EXEC:   w_next_raw = S_ALUWB;
            S_ADDIEX: w_next_raw = S_ADDIWB;
            default:  w_next_raw = S_FETCH;
        endcase
    end

    assign w_next   = w_hold ? r_state : w_next_raw;
    assign w_retire = is_retire_state(r_state) && !w_hold;

    // State register, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_illegal_set) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // FETCH must not load IR/PC until the memory has actually returned the word.
    assign pc_write   = w_ctrl.pc_write & w_fetch_ok;
    assign ir_write   = w_ctrl.ir_write & w_fetch_ok;
    assign pc_en      = pc_write | (w_ctrl.branch & zero);
    assign branch     = w_ctrl.branch;
    assign iord       = w_ctrl.iord;
    assign mem_write  = w_ctrl.mem_write;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign reg_write  = w_ctrl.reg_write;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign alu_op     = w_ctrl.alu_op;
    assign pc_src     = w_ctrl.pc_src;
    assign state      = r_state;
    assign illegal_op = r_illegal;
    assign retired    = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; expected values are hand-computed.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
`ifdef MIPS_CTRL_MEM_READY_EN
    logic        mem_ready = 1'b1;
`endif
    logic        pc_en, pc_write, branch, iord, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state;
    logic [31:0] retired;

    int n_vec = 0;
    int n_miss = 0;
    int exp_ret = 0;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef MIPS_CTRL_MEM_READY_EN
        .mem_ready  (mem_ready),
`endif
        .opcode     (opcode),
        .zero       (zero),
        .pc_en      (pc_en),
        .pc_write   (pc_write),
        .branch     (branch),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .state      (state),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (state !== 4'd0) begin n_miss++; $display("FAIL rst_state got=%0d exp=0", state); end
        n_vec++; if (retired !== 32'd0) begin n_miss++; $display("FAIL rst_retired got=%0d exp=0", retired); end
        n_vec++; if (illegal_op !== 1'b0) begin n_miss++; $display("FAIL rst_illegal got=%b exp=0", illegal_op); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if ({ir_write, pc_write, alu_src_b} !== 4'b1101) begin n_miss++;
            $display("FAIL fetch_outs got=%b exp=1101", {ir_write, pc_write, alu_src_b}); end
        n_vec++; if ({iord, reg_write, mem_write, branch} !== 4'b0000) begin n_miss++;
            $display("FAIL fetch_idle got=%b exp=0000", {iord, reg_write, mem_write, branch}); end
        opcode = 6'b100011;
        tick(); tick(); tick();
        n_vec++; if (state !== 4'd3 || iord !== 1'b1) begin n_miss++;
            $display("FAIL memrd_reach state=%0d iord=%b exp=3/1", state, iord); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (state !== 4'd0) begin n_miss++; $display("FAIL async_rst_state got=%0d exp=0", state); end
        n_vec++; if (retired !== 32'd0 || illegal_op !== 1'b0) begin n_miss++;
            $display("FAIL async_rst_cnt retired=%0d illegal=%b exp=0/0", retired, illegal_op); end
        n_vec++; if (ir_write !== 1'b1 || iord !== 1'b0) begin n_miss++;
            $display("FAIL async_rst_outs ir_write=%b iord=%b exp=1/0", ir_write, iord); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (state !== exp_s[i]) begin n_miss++;
                $display("FAIL lw_state step=%0d got=%0d exp=%0d", i, state, exp_s[i]); end
            if (exp_s[i] == 4'd4) begin
                n_vec++; if ({reg_write, mem_to_reg} !== 2'b11) begin n_miss++;
                    $display("FAIL lw_wb got=%b exp=11", {reg_write, mem_to_reg}); end
            end
        end
        exp_ret++;
        n_vec++; if (retired !== 32'(exp_ret)) begin n_miss++;
            $display("FAIL lw_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            opcode = 6'b000100;
            zero = z[0];
            tick();
            tick();
            n_vec++; if (state !== 4'd8) begin n_miss++; $display("FAIL beq_state z=%0d got=%0d exp=8", z, state); end
            n_vec++; if (pc_en !== z[0] || pc_src !== 2'b01 || branch !== 1'b1 || alu_op !== 2'b01) begin n_miss++;
                $display("FAIL beq_outs z=%0d pc_en=%b pc_src=%b branch=%b alu_op=%b exp=%0d/01/1/01",
                         z, pc_en, pc_src, branch, alu_op, z); end
            tick();
            n_vec++; if (state !== 4'd0) begin n_miss++; $display("FAIL beq_done z=%0d got=%0d exp=0", z, state); end
            exp_ret++;
            n_vec++; if (retired !== 32'(exp_ret)) begin n_miss++;
                $display("FAIL beq_retired got=%0d exp=%0d", retired, exp_ret); end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        opcode = 6'b111111;
        tick();
        n_vec++; if (state !== 4'd1) begin n_miss++; $display("FAIL ill_decode got=%0d exp=1", state); end
        tick();
        n_vec++; if (state !== 4'd0 || illegal_op !== 1'b1) begin n_miss++;
            $display("FAIL ill_return state=%0d illegal=%b exp=0/1", state, illegal_op); end
        n_vec++; if (retired !== 32'(exp_ret)) begin n_miss++;
            $display("FAIL ill_retired got=%0d exp=%0d", retired, exp_ret); end
        opcode = 6'b000000;
        tick(); tick(); tick(); tick();
        exp_ret++;
        n_vec++; if (state !== 4'd0 || illegal_op !== 1'b1) begin n_miss++;
            $display("FAIL ill_sticky state=%0d illegal=%b exp=0/1", state, illegal_op); end
        n_vec++; if (retired !== 32'(exp_ret)) begin n_miss++;
            $display("FAIL ill_r_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [4] = '{6'b000000, 6'b001000, 6'b000010, 6'b101011};
        int         lat [4] = '{4, 4, 3, 4};
        int total = 0;
        int cyc;
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            cyc = 0;
            do begin
                tick();
                cyc++;
                if (state == 4'd7) begin
                    n_vec++; if ({reg_dst, reg_write} !== 2'b11) begin n_miss++;
                        $display("FAIL aluwb got=%b exp=11", {reg_dst, reg_write}); end
                end
                if (state == 4'd10) begin
                    n_vec++; if ({reg_dst, reg_write} !== 2'b01) begin n_miss++;
                        $display("FAIL addiwb got=%b exp=01", {reg_dst, reg_write}); end
                end
                if (state == 4'd11) begin
                    n_vec++; if ({pc_en, pc_src} !== 3'b110) begin n_miss++;
                        $display("FAIL jump got=%b exp=110", {pc_en, pc_src}); end
                end
                if (state == 4'd5) begin
                    n_vec++; if ({iord, mem_write} !== 2'b11) begin n_miss++;
                        $display("FAIL memwr got=%b exp=11", {iord, mem_write}); end
                end
            end while (state != 4'd0 && cyc < 8);
            n_vec++; if (cyc != lat[k]) begin n_miss++;
                $display("FAIL b2b_latency op=%b got=%0d exp=%0d", ops[k], cyc, lat[k]); end
            total += cyc;
        end
        exp_ret += 4;
        n_vec++; if (total != 15) begin n_miss++; $display("FAIL b2b_total got=%0d exp=15", total); end
        n_vec++; if (retired !== 32'(exp_ret)) begin n_miss++;
            $display("FAIL b2b_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

`ifdef MIPS_CTRL_MEM_READY_EN
    task automatic test_mem_ready();
        opcode = 6'b000010;
        mem_ready = 1'b0;
        #1;
        n_vec++; if ({ir_write, pc_write, pc_en} !== 3'b000) begin n_miss++;
            $display("FAIL mr_gate got=%b exp=000", {ir_write, pc_write, pc_en}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (state !== 4'd0 || ir_write !== 1'b0) begin n_miss++;
                $display("FAIL mr_hold cyc=%0d state=%0d ir_write=%b exp=0/0", i, state, ir_write); end
        end
        mem_ready = 1'b1;
        #1;
        n_vec++; if ({ir_write, pc_write} !== 2'b11) begin n_miss++;
            $display("FAIL mr_release got=%b exp=11", {ir_write, pc_write}); end
        tick();
        n_vec++; if (state !== 4'd1) begin n_miss++; $display("FAIL mr_decode got=%0d exp=1", state); end
        tick(); tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_beq();
        test_illegal();
        test_back_to_back();
`ifdef MIPS_CTRL_MEM_READY_EN
        test_mem_ready();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
